// File: rtl/acc_cmd_adapter_pkg.sv
// Shared command-stream definitions for the manager and the accelerator adapters:
// command codes, header field positions and the adapter FSM state encoding.
package acc_cmd_adapter_pkg;

  localparam logic [7:0] CmdExec   = 8'h01;
  localparam logic [7:0] CmdFinish = 8'h03;

  localparam int unsigned HdrCodeLsb  = 0;
  localparam int unsigned HdrNargsLsb = 8;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRxTid    = 3'd1;
  localparam logic [2:0] StRxArgs   = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StTxHdr    = 3'd4;
  localparam logic [2:0] StTxTid    = 3'd5;
  localparam logic [2:0] StDrain    = 3'd6;

  function automatic logic [63:0] finish_hdr(input logic [7:0] acc_id);
    return {40'b0, acc_id, 8'h00, CmdFinish};
  endfunction

endpackage

// File: rtl/acc_cmd_adapter.sv
// Accelerator command adapter: parses execute commands from the manager, streams arguments
// to the core, waits for completion and returns a two-word finish message.
module acc_cmd_adapter
  import acc_cmd_adapter_pkg::*;
#(
  parameter int unsigned MAX_ACCS = 16,
  parameter int unsigned ACC_ID   = 0,
  parameter int unsigned MAX_ARGS = 15,
  localparam int unsigned TidW    = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
  input  logic            aclk,
  input  logic            aresetn,

  input  logic            cmdin_in_tvalid,
  output logic            cmdin_in_tready,
  input  logic [63:0]     cmdin_in_tdata,
  input  logic            cmdin_in_tlast,

  output logic            cmdout_out_tvalid,
  input  logic            cmdout_out_tready,
  output logic [TidW-1:0] cmdout_out_tid,
  output logic [63:0]     cmdout_out_tdata,

  output logic            task_tvalid,
  input  logic            task_tready,
  output logic [63:0]     task_tdata,
  output logic            task_tlast,

  output logic [63:0]     task_id,
  output logic            busy,
  input  logic            acc_done,
  output logic [7:0]      err_count,
  output logic            err_sticky
);

  localparam logic [7:0] MaxArgs = 8'(MAX_ARGS);

  logic [2:0]  state_q, state_d;
  logic [7:0]  nargs_q, nargs_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] task_id_q, task_id_d;
  logic        drain_to_wait_q, drain_to_wait_d;
  logic [7:0]  err_count_q;
  logic        err_sticky_q;
  logic        live_q;
  logic        err_event;
  logic [7:0]  hdr_code, hdr_nargs;
  logic        last_arg;

  assign hdr_code  = cmdin_in_tdata[HdrCodeLsb +: 8];
  assign hdr_nargs = cmdin_in_tdata[HdrNargsLsb +: 8];
  assign last_arg  = (cnt_q == nargs_q - 8'd1);

  always_comb begin
    state_d           = state_q;
    nargs_d           = nargs_q;
    cnt_d             = cnt_q;
    task_id_d         = task_id_q;
    drain_to_wait_d   = drain_to_wait_q;
    err_event         = 1'b0;
    cmdin_in_tready   = 1'b0;
    task_tvalid       = 1'b0;
    task_tdata        = cmdin_in_tdata;
    task_tlast        = 1'b0;
    cmdout_out_tvalid = 1'b0;
    cmdout_out_tdata  = '0;
    case (state_q)
      StIdle: begin
        // live_q keeps tready low while in reset and until the first clock after it
        cmdin_in_tready = live_q;
        if (cmdin_in_tvalid && live_q) begin
          nargs_d         = hdr_nargs;
          cnt_d           = '0;
          drain_to_wait_d = 1'b0;
          if (hdr_code != CmdExec || hdr_nargs > MaxArgs || cmdin_in_tlast) begin
            err_event = 1'b1;
            // A bad header that already carries tlast has nothing left to drain
            state_d   = cmdin_in_tlast ? StIdle : StDrain;
          end else begin
            state_d = StRxTid;
          end
        end
      end
      StRxTid: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid) begin
          task_id_d = cmdin_in_tdata;
          if (nargs_q == 8'd0 && cmdin_in_tlast) begin
            state_d = StWaitDone;
          end else if (nargs_q != 8'd0 && !cmdin_in_tlast) begin
            state_d = StRxArgs;
          end else begin
            err_event = 1'b1;
            state_d   = cmdin_in_tlast ? StIdle : StDrain;
          end
        end
      end
      StRxArgs: begin
        task_tvalid     = cmdin_in_tvalid;
        cmdin_in_tready = task_tready;
        task_tlast      = last_arg || cmdin_in_tlast;
        if (cmdin_in_tvalid && task_tready) begin
          cnt_d = cnt_q + 8'd1;
          if (last_arg) begin
            if (cmdin_in_tlast) begin
              state_d = StWaitDone;
            end else begin
              err_event       = 1'b1;
              drain_to_wait_d = 1'b1;
              state_d         = StDrain;
            end
          end else if (cmdin_in_tlast) begin
            err_event = 1'b1;
            state_d   = StWaitDone;
          end
        end
      end
      StDrain: begin
        cmdin_in_tready = 1'b1;
        if (cmdin_in_tvalid && cmdin_in_tlast) begin
          state_d         = drain_to_wait_q ? StWaitDone : StIdle;
          drain_to_wait_d = 1'b0;
        end
      end
      StWaitDone: begin
        if (acc_done) state_d = StTxHdr;
      end
      StTxHdr: begin
        cmdout_out_tvalid = 1'b1;
        cmdout_out_tdata  = finish_hdr(8'(ACC_ID));
        if (cmdout_out_tready) state_d = StTxTid;
      end
      StTxTid: begin
        cmdout_out_tvalid = 1'b1;
        cmdout_out_tdata  = task_id_q;
        if (cmdout_out_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= StIdle;
      nargs_q         <= '0;
      cnt_q           <= '0;
      task_id_q       <= '0;
      drain_to_wait_q <= 1'b0;
      err_count_q     <= '0;
      err_sticky_q    <= 1'b0;
      live_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      nargs_q         <= nargs_d;
      cnt_q           <= cnt_d;
      task_id_q       <= task_id_d;
      drain_to_wait_q <= drain_to_wait_d;
      live_q          <= 1'b1;
      if (err_event) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != 8'hff) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign cmdout_out_tid = TidW'(ACC_ID);
  assign task_id        = task_id_q;
  assign busy           = (state_q != StIdle);
  assign err_count      = err_count_q;
  assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_acc_cmd_adapter.sv
// Directed bench for acc_cmd_adapter: drives commands, records core and finish streams,
// and compares them against hand-computed expectations.
module tb_acc_cmd_adapter;

  localparam int unsigned AccId = 5;
  localparam logic [63:0] FinHdr = 64'h0000_0000_0005_0003;

  logic        aclk;
  logic        aresetn;
  logic        cmdin_in_tvalid, cmdin_in_tready, cmdin_in_tlast;
  logic [63:0] cmdin_in_tdata;
  logic        cmdout_out_tvalid, cmdout_out_tready;
  logic [3:0]  cmdout_out_tid;
  logic [63:0] cmdout_out_tdata;
  logic        task_tvalid, task_tready, task_tlast;
  logic [63:0] task_tdata;
  logic [63:0] task_id;
  logic        busy, acc_done, err_sticky;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  logic [64:0] task_q[$];
  logic [63:0] fin_q[$];

  acc_cmd_adapter #(
    .MAX_ACCS(16),
    .ACC_ID  (AccId),
    .MAX_ARGS(15)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cmdin_in_tvalid  (cmdin_in_tvalid),
    .cmdin_in_tready  (cmdin_in_tready),
    .cmdin_in_tdata   (cmdin_in_tdata),
    .cmdin_in_tlast   (cmdin_in_tlast),
    .cmdout_out_tvalid(cmdout_out_tvalid),
    .cmdout_out_tready(cmdout_out_tready),
    .cmdout_out_tid   (cmdout_out_tid),
    .cmdout_out_tdata (cmdout_out_tdata),
    .task_tvalid      (task_tvalid),
    .task_tready      (task_tready),
    .task_tdata       (task_tdata),
    .task_tlast       (task_tlast),
    .task_id          (task_id),
    .busy             (busy),
    .acc_done         (acc_done),
    .err_count        (err_count),
    .err_sticky       (err_sticky)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfers happen on the rising edge, so the falling edge sees what is about to move.
  always @(negedge aclk) begin
    if (aresetn && task_tvalid && task_tready) task_q.push_back({task_tlast, task_tdata});
    if (aresetn && cmdout_out_tvalid && cmdout_out_tready) begin
      fin_q.push_back(cmdout_out_tdata);
      check_eq("fin_tid", 65'(cmdout_out_tid), 65'(AccId));
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    int n = 0;
    cmdin_in_tvalid = 1'b1;
    cmdin_in_tdata  = d;
    cmdin_in_tlast  = l;
    @(negedge aclk);
    while (!cmdin_in_tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 65'(n), 65'd0);
    step();
    cmdin_in_tvalid = 1'b0;
    cmdin_in_tlast  = 1'b0;
  endtask

  task automatic pulse_done();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
  endtask

  task automatic wait_finish();
    int n = 0;
    while (fin_q.size() < 2 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) check_eq("finish_timeout", 65'(fin_q.size()), 65'd2);
    step();
  endtask

  initial begin
    aresetn           = 1'b0;
    cmdin_in_tvalid   = 1'b0;
    cmdin_in_tdata    = '0;
    cmdin_in_tlast    = 1'b0;
    cmdout_out_tready = 1'b1;
    task_tready       = 1'b1;
    acc_done          = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_tready", 65'(cmdin_in_tready), 65'd0);
    check_eq("rst_busy", 65'(busy), 65'd0);
    check_eq("rst_fin_valid", 65'(cmdout_out_tvalid), 65'd0);
    check_eq("rst_err", 65'({err_sticky, err_count}), 65'd0);
    aresetn = 1'b1;
    step();
    check_eq("post_rst_tready", 65'(cmdin_in_tready), 65'd1);

    // Stray acc_done while idle is ignored
    pulse_done();
    repeat (3) step();
    check_eq("stray_done_busy", 65'(busy), 65'd0);
    check_eq("stray_done_fin", 65'(fin_q.size()), 65'd0);

    // Two-argument command
    send_word(64'h0201, 1'b0);
    send_word(64'hABCD, 1'b0);
    send_word(64'h11, 1'b0);
    send_word(64'h22, 1'b1);
    check_eq("t1_task_id", 65'(task_id), 65'hABCD);
    check_eq("t1_busy_wait", 65'(busy), 65'd1);
    check_eq("t1_tready_wait", 65'(cmdin_in_tready), 65'd0);
    pulse_done();
    wait_finish();
    check_eq("t1_nargs", 65'(task_q.size()), 65'd2);
    check_eq("t1_arg0", task_q[0], {1'b0, 64'h11});
    check_eq("t1_arg1", task_q[1], {1'b1, 64'h22});
    check_eq("t1_fin_hdr", 65'(fin_q[0]), 65'(FinHdr));
    check_eq("t1_fin_tid", 65'(fin_q[1]), 65'hABCD);
    check_eq("t1_back_to_back", 65'({busy, cmdin_in_tready}), 65'b01);
    task_q.delete();
    fin_q.delete();

    // Zero-argument command
    send_word(64'h0001, 1'b0);
    send_word(64'h55, 1'b1);
    pulse_done();
    wait_finish();
    check_eq("t2_no_args", 65'(task_q.size()), 65'd0);
    check_eq("t2_fin_tid", 65'(fin_q[1]), 65'h55);
    check_eq("t2_err", 65'(err_count), 65'd0);
    fin_q.delete();

    // Unknown code 0x07, three words all drained
    send_word(64'h0207, 1'b0);
    send_word(64'h1, 1'b0);
    send_word(64'h2, 1'b1);
    check_eq("t3_idle", 65'(busy), 65'd0);
    check_eq("t3_err_count", 65'(err_count), 65'd1);
    check_eq("t3_err_sticky", 65'(err_sticky), 65'd1);
    pulse_done();
    repeat (8) step();
    check_eq("t3_no_finish", 65'(fin_q.size()), 65'd0);
    check_eq("t3_no_args", 65'(task_q.size()), 65'd0);

    // Finish backpressure during the header word
    cmdout_out_tready = 1'b0;
    send_word(64'h0101, 1'b0);
    send_word(64'h77, 1'b0);
    send_word(64'h99, 1'b1);
    pulse_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("t4_stall_valid", 65'(cmdout_out_tvalid), 65'd1);
      check_eq("t4_stall_data", 65'(cmdout_out_tdata), 65'(FinHdr));
    end
    step();
    cmdout_out_tready = 1'b1;
    wait_finish();
    repeat (3) step();
    check_eq("t4_fin_count", 65'(fin_q.size()), 65'd2);
    check_eq("t4_fin_hdr", 65'(fin_q[0]), 65'(FinHdr));
    check_eq("t4_fin_tid", 65'(fin_q[1]), 65'h77);
    task_q.delete();
    fin_q.delete();

    // N=3 with tlast on the second argument
    send_word(64'h0301, 1'b0);
    send_word(64'h33, 1'b0);
    send_word(64'hA0, 1'b0);
    send_word(64'hA1, 1'b1);
    check_eq("t5_err_count", 65'(err_count), 65'd2);
    pulse_done();
    wait_finish();
    check_eq("t5_nargs", 65'(task_q.size()), 65'd2);
    check_eq("t5_arg0", task_q[0], {1'b0, 64'hA0});
    check_eq("t5_arg1_forced_last", task_q[1], {1'b1, 64'hA1});
    check_eq("t5_fin_tid", 65'(fin_q[1]), 65'h33);
    task_q.delete();
    fin_q.delete();

    // Reset during argument reception
    send_word(64'h0201, 1'b0);
    send_word(64'h44, 1'b0);
    send_word(64'hB0, 1'b0);
    cmdin_in_tvalid = 1'b1;
    cmdin_in_tdata  = 64'hB1;
    aresetn         = 1'b0;
    #1;
    check_eq("t6_rst_task_valid", 65'(task_tvalid), 65'd0);
    check_eq("t6_rst_tready", 65'(cmdin_in_tready), 65'd0);
    check_eq("t6_rst_state", 65'({busy, err_sticky, err_count}), 65'd0);
    check_eq("t6_rst_task_id", 65'(task_id), 65'd0);
    cmdin_in_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    task_q.delete();
    send_word(64'h0101, 1'b0);
    send_word(64'h66, 1'b0);
    send_word(64'hC0, 1'b1);
    pulse_done();
    wait_finish();
    repeat (3) step();
    check_eq("t6_fin_count", 65'(fin_q.size()), 65'd2);
    check_eq("t6_fin_tid", 65'(fin_q[1]), 65'h66);
    check_eq("t6_arg", task_q[0], {1'b1, 64'hC0});
    fin_q.delete();

    // Argument count above MAX_ARGS is rejected and drained
    send_word(64'h1001, 1'b0);
    send_word(64'h5, 1'b1);
    check_eq("t7_err_count", 65'(err_count), 65'd1);
    check_eq("t7_idle", 65'(busy), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
